// File: rtl/bsg_idiv_unsigned_recip_cfg_pkg.sv
// Shared definitions for the reciprocal-multiply division configurator:
// FSM state codes and the width helpers used by the configurator and the
// multiply/shift datapath that consumes its outputs.
package bsg_idiv_unsigned_recip_cfg_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;

    // ceil(log2(x)), never less than 1 so a vector built from it is legal
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // Width of the multiplier m for an N-bit numerator
    function automatic int mul_width(input int numer_width);
        return numer_width + 1;
    endfunction

    // Width of the extra shift s (0..N) for an N-bit numerator
    function automatic int shift_width(input int numer_width);
        return safe_clog2(numer_width + 1);
    endfunction

endpackage

// File: rtl/bsg_idiv_unsigned_recip_cfg_gen_clog2.sv
// Combinational ceil(log2 d) over the denominator, plus flags for d==0
// and d>2^N (the two cases where no reciprocal needs computing).
module bsg_idiv_unsigned_recip_clog2
    import bsg_idiv_unsigned_recip_cfg_pkg::*;
#(
    parameter  int numer_width_p  = 8,
    parameter  int denom_width_p  = 8,
    localparam int shift_width_lp = shift_width(numer_width_p)
) (
    input  logic [denom_width_p-1:0]  denom_i,
    output logic [shift_width_lp-1:0] shift_o,
    output logic                      zero_o,
    output logic                      over_o
);

    localparam int pos_width_lp = safe_clog2(denom_width_p + 1);
    localparam int cmp_width_lp =
        ((denom_width_p > numer_width_p + 1) ? denom_width_p : numer_width_p + 1) + 1;

    logic [pos_width_lp-1:0] msb_pos;
    logic [pos_width_lp-1:0] ceil_pos;
    logic                    pow2;
    logic [cmp_width_lp-1:0] denom_wide;

    // Priority encoder: index of the highest set bit of d (0 when d==0)
    always_comb begin
        msb_pos = '0;
        for (int i = 0; i < denom_width_p; i++) begin
            if (denom_i[i]) msb_pos = pos_width_lp'(i);
        end
    end

    // A power of two needs exactly msb bits; anything else rounds up one
    assign pow2     = ((denom_i & (denom_i - denom_width_p'(1))) == '0);
    assign ceil_pos = pow2 ? msb_pos : (msb_pos + pos_width_lp'(1));
    assign shift_o  = shift_width_lp'(ceil_pos);

    assign zero_o     = (denom_i == '0);
    assign denom_wide = cmp_width_lp'(denom_i);
    assign over_o     = (denom_wide > (cmp_width_lp'(1) << numer_width_p));

endmodule

// File: rtl/bsg_idiv_unsigned_recip_cfg_gen.sv
// Sequential configurator: accepts a denominator d and produces (m, s) with
// floor(n/d) == (n*m) >> (N+s) for all N-bit n. m = ceil(2^(N+s)/d) is built
// one restoring-division bit per cycle, then rounded up if any remainder is left.
module bsg_idiv_unsigned_recip_cfg_gen
    import bsg_idiv_unsigned_recip_cfg_pkg::*;
#(
    parameter  int numer_width_p  = 8,
    parameter  int denom_width_p  = 8,
    localparam int mul_width_lp   = mul_width(numer_width_p),
    localparam int shift_width_lp = shift_width(numer_width_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    input  logic [denom_width_p-1:0]  denom_i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [mul_width_lp-1:0]   cfg_multiply_o,
    output logic [shift_width_lp-1:0] cfg_shift_o,
    output logic                      div_zero_o
);

    localparam int rem_width_lp = denom_width_p + 1;

    logic [1:0]                state_q, state_d;
    logic [rem_width_lp-1:0]   rem_q, rem_d;
    logic [mul_width_lp-1:0]   quot_q, quot_d;
    logic [shift_width_lp-1:0] cnt_q, cnt_d;
    logic [denom_width_p-1:0]  denom_q, denom_d;
    logic [shift_width_lp-1:0] calc_shift_q, calc_shift_d;
    logic                      v_q, v_d;
    logic [mul_width_lp-1:0]   mul_q, mul_d;
    logic [shift_width_lp-1:0] shift_q, shift_d;
    logic                      dz_q, dz_d;

    logic [shift_width_lp-1:0] c2_shift;
    logic                      c2_zero;
    logic                      c2_over;
    logic                      accept;
    logic [rem_width_lp-1:0]   rem_x2;
    logic [rem_width_lp-1:0]   denom_ext;
    logic                      rem_ge;

    bsg_idiv_unsigned_recip_clog2 #(
        .numer_width_p (numer_width_p),
        .denom_width_p (denom_width_p)
    ) clog2 (
        .denom_i (denom_i),
        .shift_o (c2_shift),
        .zero_o  (c2_zero),
        .over_o  (c2_over)
    );

    assign ready_o = (state_q == IDLE);
    assign accept  = v_i & ready_o;

    // The remainder is always below d, so doubling it never loses its top bit
    assign rem_x2    = {rem_q[denom_width_p-1:0], 1'b0};
    assign denom_ext = {1'b0, denom_q};
    assign rem_ge    = (rem_x2 >= denom_ext);

    // Next-state logic: accept / one division step / round and publish
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        quot_d       = quot_q;
        cnt_d        = cnt_q;
        denom_d      = denom_q;
        calc_shift_d = calc_shift_q;
        v_d          = v_q;
        mul_d        = mul_q;
        shift_d      = shift_q;
        dz_d         = dz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    denom_d      = denom_i;
                    calc_shift_d = c2_shift;
                    if (c2_zero || c2_over) begin
                        // Quotient is undefined (d==0) or always zero (d>2^N)
                        mul_d   = '0;
                        shift_d = '0;
                        dz_d    = c2_zero;
                        v_d     = 1'b1;
                    end else begin
                        // 2^s/d is in [1,2): leading quotient bit is 1
                        rem_d   = (rem_width_lp'(1) << c2_shift) - {1'b0, denom_i};
                        quot_d  = mul_width_lp'(1);
                        cnt_d   = shift_width_lp'(numer_width_p);
                        v_d     = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (rem_ge) begin
                    rem_d  = rem_x2 - denom_ext;
                    quot_d = {quot_q[mul_width_lp-2:0], 1'b1};
                end else begin
                    rem_d  = rem_x2;
                    quot_d = {quot_q[mul_width_lp-2:0], 1'b0};
                end
                cnt_d = cnt_q - shift_width_lp'(1);
                if (cnt_q == shift_width_lp'(1)) state_d = ROUND;
            end
            ROUND: begin
                mul_d   = quot_q + mul_width_lp'(rem_q != '0);
                shift_d = calc_shift_q;
                dz_d    = 1'b0;
                v_d     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and published configuration; reset aborts any computation
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            v_q     <= 1'b0;
            mul_q   <= '0;
            shift_q <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            mul_q   <= mul_d;
            shift_q <= shift_d;
            dz_q    <= dz_d;
        end
    end

    // Working registers of the division; always reloaded on accept
    always_ff @(posedge clk_i) begin
        rem_q        <= rem_d;
        quot_q       <= quot_d;
        cnt_q        <= cnt_d;
        denom_q      <= denom_d;
        calc_shift_q <= calc_shift_d;
    end

    assign v_o            = v_q;
    assign cfg_multiply_o = mul_q;
    assign cfg_shift_o    = shift_q;
    assign div_zero_o     = dz_q;

endmodule

// File: tb/tb_bsg_idiv_unsigned_recip_cfg_gen.sv
// Scoreboard bench for the reciprocal configurator (N=8, D=16).
module tb_bsg_idiv_unsigned_recip_cfg_gen;

    localparam int N  = 8;
    localparam int D  = 16;
    localparam int MW = N + 1;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          v_i;
    logic [D-1:0]  denom_i;
    logic          ready_o;
    logic          v_o;
    logic [MW-1:0] cfg_multiply_o;
    logic [SW-1:0] cfg_shift_o;
    logic          div_zero_o;

    bsg_idiv_unsigned_recip_cfg_gen #(
        .numer_width_p (N),
        .denom_width_p (D)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .v_i            (v_i),
        .denom_i        (denom_i),
        .ready_o        (ready_o),
        .v_o            (v_o),
        .cfg_multiply_o (cfg_multiply_o),
        .cfg_shift_o    (cfg_shift_o),
        .div_zero_o     (div_zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     due;
        int     acc;
        bit     gen;
        longint d;
        longint m;
        int     s;
        bit     dz;
    } exp_t;

    exp_t sbq[$];
    int   cyc        = 0;
    bit   rst_seen   = 1'b0;
    int   n_chk      = 0;
    int   n_fail     = 0;
    int   busy_until = -1;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset_i;
    end

    // Reference: smallest s with 2^s >= d, m = ceil(2^(N+s)/d)
    function automatic void ref_cfg(input longint d, output longint m, output int s,
                                    output bit dz, output bit gen);
        m = 0; s = 0; dz = 0; gen = 0;
        if (d == 0) begin
            dz = 1;
        end else if (d > (longint'(1) << N)) begin
            dz = 0;
        end else begin
            while ((longint'(1) << s) < d) s++;
            m   = ((longint'(1) << (N + s)) + d - 1) / d;
            gen = 1;
        end
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_out(input string name, input bit ev, input longint em,
                           input int es, input bit edz);
        n_chk++;
        if (v_o !== ev || cfg_multiply_o !== MW'(em) || cfg_shift_o !== SW'(es) ||
            div_zero_o !== edz) begin
            n_fail++;
            $display("FAIL %s: got v=%0d m=%0d s=%0d dz=%0d, expected v=%0d m=%0d s=%0d dz=%0d (cycle %0d)",
                     name, v_o, cfg_multiply_o, cfg_shift_o, div_zero_o, ev, em, es, edz, cyc);
        end
    endtask

    // Monitor: compares results when due, otherwise checks hold / busy behaviour
    initial begin : monitor
        exp_t   e;
        bit     hv;
        longint hm;
        int     hs;
        bit     hdz;
        hv = 0; hm = 0; hs = 0; hdz = 0;
        wait (rst_seen);
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                hv = 0; hm = 0; hs = 0; hdz = 0;
                chk_out("reset_state", 0, 0, 0, 0);
                chk(ready_o === 1'b1, "reset_ready", ready_o, 1);
            end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                chk(0, "missed_result", cyc, e.due);
            end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk_out($sformatf("cfg d=%0d", e.d), 1, e.m, e.s, e.dz);
                hv = 1; hm = e.m; hs = e.s; hdz = e.dz;
                if (!e.dz) begin
                    for (int k = 0; k < 4; k++) begin
                        longint n;
                        longint quo;
                        n   = (k == 0) ? ((longint'(1) << N) - 1) : longint'($urandom_range(0, (1 << N) - 1));
                        quo = (n * longint'(cfg_multiply_o)) >> (N + int'(cfg_shift_o));
                        chk(quo == n / e.d, $sformatf("quot n=%0d d=%0d", n, e.d), quo, n / e.d);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].gen && cyc >= sbq[0].acc) begin
                chk_out("busy_hold", 0, hm, hs, hdz);
            end else begin
                chk_out("idle_hold", hv, hm, hs, hdz);
            end
        end
    end

    // Present d until the model says it is accepted, then record the expectation
    task automatic send(input longint d);
        exp_t e;
        bit   exp_rdy;
        int   guard;
        guard   = 0;
        v_i     = 1'b1;
        denom_i = D'(d);
        forever begin
            exp_rdy = (cyc > busy_until);
            chk(ready_o === exp_rdy, "ready_o", ready_o, exp_rdy);
            if (exp_rdy) break;
            guard++;
            if (guard > 50) begin
                chk(0, "accept_timeout", guard, 50);
                v_i = 1'b0;
                return;
            end
            @(negedge clk);
        end
        ref_cfg(d, e.m, e.s, e.dz, e.gen);
        e.d   = d;
        e.acc = cyc + 1;
        e.due = e.gen ? (cyc + N + 2) : (cyc + 1);
        if (e.gen) busy_until = cyc + 1 + N;
        sbq.push_back(e);
        @(negedge clk);
        v_i = 1'b0;
    endtask

    task automatic idle(input int k);
        v_i = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        v_i     = 1'b0;
        #1;
        sbq.delete();
        busy_until = -1;
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    initial begin : driver
        longint dirs[8] = '{3, 1, 128, 129, 0, 300, 256, 5};
        int     w;
        reset_i = 1'b1;
        v_i     = 1'b0;
        denom_i = '0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        idle(2);

        foreach (dirs[i]) begin
            send(dirs[i]);
            idle(i % 3);
        end

        // Back-to-back fast-path accepts, then a general accept right after
        send(0); send(300); send(0); send(1000); send(7); send(65535);
        idle(1);

        // Reset three cycles into a computation
        send(129);
        idle(N + 2);
        send(3);
        repeat (2) @(negedge clk);
        pulse_reset();
        send(5);
        idle(N + 3);

        // Every denominator below 2^N, plus 2^N itself
        for (int d = 0; d <= 256; d++) begin
            send(d);
            idle($urandom_range(0, 2));
        end

        // Random denominators over the full input range
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 1) send(longint'($urandom_range(0, 300)));
            else send(longint'($urandom_range(0, 65535)));
            idle($urandom_range(0, 3));
        end

        w = 0;
        while (sbq.size() > 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() > 0) chk(0, "drain_timeout", sbq.size(), 0);
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
